mem_port_requester: RTL and testbench



---
 rtl/mem_port_requester_if.sv | 38 +++
 rtl/mem_port_requester.sv | 136 +++++++++++++
 tb/tb_mem_port_requester.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_requester_if.sv
// Client command/response and memory-port signals of one mem_port_requester.
// master = the requester, slave = the client plus the memory port it drives.
interface mem_port_requester_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_wen;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_wen;
    logic              mem_valid_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_valid_out;
    logic              mem_freeze;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdata, cmd_wen, rsp_ready,
               mem_data_out, mem_valid_out, mem_freeze,
        output cmd_ready, rsp_valid, rsp_data,
               mem_addr, mem_data_in, mem_wen, mem_valid_in
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdata, cmd_wen, rsp_ready,
               mem_data_out, mem_valid_out, mem_freeze,
        input  cmd_ready, rsp_valid, rsp_data,
               mem_addr, mem_data_in, mem_wen, mem_valid_in
    );
endinterface

// File: rtl/mem_port_requester.sv
// Client-side initiator for one memory port: request register, outstanding/kind
// tracking and a credit-protected read response FIFO.
module mem_port_requester #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    mem_port_requester_if.master       bus,
    output logic [$clog2(MAX_OUT):0]   o_out_cnt,
    output logic                       o_idle,
    output logic                       o_err_unexp_rsp
);
    localparam int unsigned OCW = $clog2(MAX_OUT) + 1;
    localparam int unsigned CRW = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned RPW = $clog2(RSP_DEPTH);
    // Kind FIFO gets at least two entries so its pointer is never zero-width.
    localparam int unsigned KD  = (MAX_OUT > 1) ? MAX_OUT : 2;
    localparam int unsigned KPW = $clog2(KD);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wen;
    logic [OCW-1:0]    r_out_cnt;
    logic [CRW-1:0]    r_credits;
    logic              r_err;
    logic [KD-1:0]     r_kind;
    logic [KPW-1:0]    r_kwr;
    logic [KPW-1:0]    r_krd;
    logic [DATA_W-1:0] r_rsp_mem [RSP_DEPTH];
    logic [RPW-1:0]    r_rwr;
    logic [RPW-1:0]    r_rrd;
    logic [CRW-1:0]    r_rcnt;
    logic              r_rsp_valid;

    logic              w_acc;
    logic [OCW:0]      w_out_sum;
    logic              w_cmd_ready;
    logic              w_cmd_hs;
    logic              w_rd_hs;
    logic              w_rsp_pop;
    logic              w_resp_ok;
    logic              w_unexp;
    logic              w_rsp_push;
    logic [CRW-1:0]    w_rcnt_nxt;

    assign w_acc       = r_valid && !bus.mem_freeze;
    assign w_out_sum   = (OCW+1)'(r_out_cnt) + (OCW+1)'(r_valid);
    // Reads also need a free credit: the memory output cannot be back-pressured.
    assign w_cmd_ready = !i_reset && (!r_valid || w_acc)
                         && (w_out_sum < (OCW+1)'(MAX_OUT))
                         && (bus.cmd_wen || (r_credits != '0));
    assign w_cmd_hs    = bus.cmd_valid && w_cmd_ready;
    assign w_rd_hs     = w_cmd_hs && !bus.cmd_wen;
    assign w_rsp_pop   = r_rsp_valid && bus.rsp_ready;
    assign w_resp_ok   = bus.mem_valid_out && (r_out_cnt != '0);
    assign w_unexp     = bus.mem_valid_out && (r_out_cnt == '0);
    assign w_rsp_push  = w_resp_ok && !r_kind[r_krd];
    assign w_rcnt_nxt  = r_rcnt + CRW'(w_rsp_push) - CRW'(w_rsp_pop);

    assign bus.cmd_ready    = w_cmd_ready;
    assign bus.mem_valid_in = r_valid;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_data_in  = r_wdata;
    assign bus.mem_wen      = r_wen;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_mem[r_rrd];
    assign o_out_cnt        = r_out_cnt;
    assign o_err_unexp_rsp  = r_err;
    assign o_idle           = !r_valid && (r_out_cnt == '0) && !r_rsp_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wen       <= 1'b0;
            r_out_cnt   <= '0;
            r_credits   <= CRW'(RSP_DEPTH);
            r_err       <= 1'b0;
            r_kind      <= '0;
            r_kwr       <= '0;
            r_krd       <= '0;
            r_rwr       <= '0;
            r_rrd       <= '0;
            r_rcnt      <= '0;
            r_rsp_valid <= 1'b0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                r_rsp_mem[i] <= '0;
            end
        end else begin
            if (w_cmd_hs) begin
                r_valid <= 1'b1;
                r_addr  <= bus.cmd_addr;
                r_wdata <= bus.cmd_wdata;
                r_wen   <= bus.cmd_wen;
            end else if (w_acc) begin
                r_valid <= 1'b0;
            end

            r_credits <= r_credits + CRW'(w_rsp_pop) - CRW'(w_rd_hs);

            // Kind FIFO mirrors the memory's in-order pipeline: 1 = write.
            if (w_acc) begin
                r_kind[r_kwr] <= r_wen;
                r_kwr         <= r_kwr + KPW'(1);
            end
            if (w_resp_ok) begin
                r_krd <= r_krd + KPW'(1);
            end

            if (w_acc && !w_resp_ok) begin
                r_out_cnt <= r_out_cnt + OCW'(1);
            end else if (!w_acc && w_resp_ok) begin
                r_out_cnt <= r_out_cnt - OCW'(1);
            end

            if (w_unexp) begin
                r_err <= 1'b1;
            end

            if (w_rsp_push) begin
                r_rsp_mem[r_rwr] <= bus.mem_data_out;
                r_rwr            <= r_rwr + RPW'(1);
            end
            if (w_rsp_pop) begin
                r_rrd <= r_rrd + RPW'(1);
            end
            r_rcnt      <= w_rcnt_nxt;
            r_rsp_valid <= (w_rcnt_nxt != '0);
        end
    end
endmodule

// File: tb/tb_mem_port_requester.sv
// Bench for mem_port_requester: behavioural memory port, client scoreboard,
// vector table, directed corner sequences and a randomized phase.
module tb_mem_port_requester;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned RSP_DEPTH = 4;
    localparam int unsigned MAX_OUT   = 4;
    localparam int unsigned OCW       = $clog2(MAX_OUT) + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [OCW-1:0] out_cnt;
    logic           idle;
    logic           err;

    mem_port_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_requester #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .bus            (bus),
        .o_out_cnt      (out_cnt),
        .o_idle         (idle),
        .o_err_unexp_rsp(err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Response-ready source: plain level or toggling every cycle.
    logic rdy = 1'b1;
    logic tog_mode = 1'b0;
    logic tog = 1'b0;
    always @(negedge clk) tog = ~tog;
    assign bus.rsp_ready = tog_mode ? tog : rdy;

    // Behavioural memory port: in-order, one response per accepted request.
    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } pend_t;
    logic [DATA_W-1:0] mem_arr [4096];
    pend_t             pend_q [$];
    int                cyc = 0;
    int                lat = 1;
    bit                hold = 1'b0;
    bit                inj = 1'b0;
    int                m_outst = 0;

    always @(posedge clk) begin : mem_model
        pend_t p;
        cyc++;
        if (reset) begin
            pend_q.delete();
            m_outst = 0;
            bus.mem_valid_out <= 1'b0;
            bus.mem_data_out  <= '0;
        end else begin
            if (bus.mem_valid_out && m_outst > 0) m_outst--;
            if (bus.mem_valid_in && !bus.mem_freeze) begin
                m_outst++;
                if (bus.mem_wen) begin
                    mem_arr[bus.mem_addr] = bus.mem_data_in;
                    p.data = ~bus.mem_data_in;
                end else begin
                    p.data = mem_arr[bus.mem_addr];
                end
                p.due = cyc + lat;
                pend_q.push_back(p);
            end
            if (!hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.mem_valid_out <= 1'b1;
                bus.mem_data_out  <= pend_q[0].data;
                void'(pend_q.pop_front());
            end else if (inj) begin
                bus.mem_valid_out <= 1'b1;
                bus.mem_data_out  <= 16'hDEAD;
            end else begin
                bus.mem_valid_out <= 1'b0;
            end
        end
    end

    // Client-level scoreboard: reads return the latest value written in issue order.
    logic [DATA_W-1:0] ref_mem [4096];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] last_rsp = '0;
    int rd_inflight = 0;
    int hs_cnt = 0, rd_hs_cnt = 0, rsp_cnt = 0, acc_cnt = 0, vout_cnt = 0;

    always @(posedge clk) begin : scoreboard
        logic [DATA_W-1:0] e;
        if (reset) begin
            exp_q.delete();
            rd_inflight = 0;
        end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
                hs_cnt++;
                if (bus.cmd_wen) begin
                    ref_mem[bus.cmd_addr] = bus.cmd_wdata;
                end else begin
                    check("credit_bound", 32'(rd_inflight < int'(RSP_DEPTH)), 32'd1);
                    exp_q.push_back(ref_mem[bus.cmd_addr]);
                    rd_inflight++;
                    rd_hs_cnt++;
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_cnt++;
                last_rsp = bus.rsp_data;
                check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_data", 32'(bus.rsp_data), 32'(e));
                end
                if (rd_inflight > 0) rd_inflight--;
            end
            if (bus.mem_valid_in && !bus.mem_freeze) acc_cnt++;
            if (bus.mem_valid_out) vout_cnt++;
        end
    end

    task automatic send(input logic wen, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_wen   = wen;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        #1;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) check("send_timeout", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!(idle && exp_q.size() == 0 && pend_q.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(idle), 32'd1);
    endtask

    typedef struct {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                exp_n;
        logic [DATA_W-1:0] exp_data;
    } vec_t;
    vec_t vec [8];

    initial begin
        int r0, h0, a0, v0, n;
        vec[0] = '{1'b1, 12'h012, 16'hBEEF, 0, 16'h0000};
        vec[1] = '{1'b0, 12'h012, 16'h0000, 1, 16'hBEEF};
        vec[2] = '{1'b1, 12'h000, 16'h1357, 0, 16'h0000};
        vec[3] = '{1'b1, 12'hFFF, 16'hFFFF, 0, 16'h0000};
        vec[4] = '{1'b0, 12'h000, 16'h0000, 1, 16'h1357};
        vec[5] = '{1'b0, 12'hFFF, 16'h0000, 1, 16'hFFFF};
        vec[6] = '{1'b1, 12'h012, 16'h0001, 0, 16'h0000};
        vec[7] = '{1'b0, 12'h012, 16'h0000, 1, 16'h0001};
        for (int i = 0; i < 4096; i++) begin
            mem_arr[i] = '0;
            ref_mem[i] = '0;
        end
        bus.cmd_valid  = 1'b0;
        bus.cmd_wen    = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.mem_freeze = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1 check("rst_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mem_valid_in", 32'(bus.mem_valid_in), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Vector table: one transaction per record, drained before the next
        for (int i = 0; i < 8; i++) begin
            r0 = rsp_cnt;
            send(vec[i].wen, vec[i].addr, vec[i].wdata);
            wait_idle($sformatf("vec%0d_idle", i));
            check($sformatf("vec%0d_nrsp", i), 32'(rsp_cnt - r0), 32'(vec[i].exp_n));
            if (vec[i].exp_n != 0) check($sformatf("vec%0d_data", i), 32'(last_rsp), 32'(vec[i].exp_data));
        end

        // Freeze hold with a pending write and a competing read
        lat = 3;
        bus.mem_freeze = 1'b1;
        send(1'b1, 12'h055, 16'h1234);
        bus.cmd_valid = 1'b1;
        bus.cmd_wen   = 1'b0;
        bus.cmd_addr  = 12'h055;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("frz_valid_in", 32'(bus.mem_valid_in), 32'd1);
            check("frz_addr", 32'(bus.mem_addr), 32'h055);
            check("frz_data", 32'(bus.mem_data_in), 32'h1234);
            check("frz_wen", 32'(bus.mem_wen), 32'd1);
            check("frz_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
        end
        bus.cmd_valid  = 1'b0;
        bus.mem_freeze = 1'b0;
        @(negedge clk);
        check("frz_out_cnt", 32'(out_cnt), 32'd1);
        check("frz_released", 32'(bus.mem_valid_in), 32'd0);
        wait_idle("frz_idle");

        // Credit exhaustion
        lat = 1;
        for (int i = 0; i < 6; i++) send(1'b1, 12'(12'h100 + i), 16'(16'hC000 + i));
        wait_idle("cr_fill_idle");
        rdy = 1'b0;
        r0 = rsp_cnt;
        for (int i = 0; i < 4; i++) send(1'b0, 12'(12'h100 + i), 16'h0000);
        repeat (6) @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_wen   = 1'b0;
        bus.cmd_addr  = 12'h104;
        #1 check("cr_read_blocked", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_wen   = 1'b1;
        bus.cmd_addr  = 12'h1F0;
        bus.cmd_wdata = 16'h7777;
        #1 check("cr_write_ok", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_wen  = 1'b0;
        bus.cmd_addr = 12'h104;
        h0 = rd_hs_cnt;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        repeat (5) @(negedge clk);
        check("cr_one_more_read", 32'(rd_hs_cnt - h0), 32'd1);
        bus.cmd_valid = 1'b0;
        rdy = 1'b1;
        wait_idle("cr_idle");
        check("cr_nrsp", 32'(rsp_cnt - r0), 32'd5);
        check("cr_last", 32'(last_rsp), 32'hC004);

        // Outstanding limit with withheld responses
        hold = 1'b1;
        h0 = hs_cnt; a0 = acc_cnt; v0 = vout_cnt;
        bus.cmd_valid = 1'b1;
        bus.cmd_wen   = 1'b1;
        bus.cmd_addr  = 12'h200;
        bus.cmd_wdata = 16'h3333;
        repeat (10) @(negedge clk);
        #1;
        check("mo_hs", 32'(hs_cnt - h0), 32'd4);
        check("mo_acc", 32'(acc_cnt - a0), 32'd4);
        check("mo_out_cnt", 32'(out_cnt), 32'd4);
        check("mo_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        hold = 1'b0;
        n = 0;
        while (hs_cnt - h0 < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b0;
        check("mo_fifth", 32'(hs_cnt - h0), 32'd5);
        check("mo_after_rsp", 32'((vout_cnt - v0) >= 1), 32'd1);
        wait_idle("mo_idle");

        // Interleaved W/R/W/R at address extremes, rsp_ready toggling
        tog_mode = 1'b1;
        r0 = rsp_cnt;
        send(1'b1, 12'h000, 16'hA5A5);
        send(1'b0, 12'h000, 16'h0000);
        send(1'b1, 12'hFFF, 16'h5A5A);
        send(1'b0, 12'hFFF, 16'h0000);
        wait_idle("il_idle");
        check("il_nrsp", 32'(rsp_cnt - r0), 32'd2);
        check("il_last", 32'(last_rsp), 32'h5A5A);
        tog_mode = 1'b0;

        // Unexpected response while idle
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        @(negedge clk);
        check("ue_err", 32'(err), 32'd1);
        check("ue_out_cnt", 32'(out_cnt), 32'd0);
        check("ue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("ue_sticky", 32'(err), 32'd1);
        check("ue_idle", 32'(idle), 32'd1);

        // Reset mid-transaction: FIFO occupied, 3 outstanding, request frozen
        rdy = 1'b0;
        send(1'b0, 12'h012, 16'h0000);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rr_rsp_pending", 32'(bus.rsp_valid), 32'd1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) send(1'b0, 12'(12'h100 + i), 16'h0000);
        n = 0;
        while (out_cnt != OCW'(3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rr_out3", 32'(out_cnt), 32'd3);
        bus.mem_freeze = 1'b1;
        send(1'b1, 12'h0AB, 16'h9999);
        bus.cmd_valid = 1'b1;
        bus.cmd_wen   = 1'b0;
        bus.cmd_addr  = 12'h123;
        reset = 1'b1;
        #1 check("rr_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check("rr_valid_in", 32'(bus.mem_valid_in), 32'd0);
        check("rr_addr", 32'(bus.mem_addr), 32'd0);
        check("rr_data_in", 32'(bus.mem_data_in), 32'd0);
        check("rr_wen", 32'(bus.mem_wen), 32'd0);
        check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rr_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rr_out_cnt", 32'(out_cnt), 32'd0);
        check("rr_err", 32'(err), 32'd0);
        check("rr_idle", 32'(idle), 32'd1);
        bus.cmd_valid  = 1'b0;
        bus.mem_freeze = 1'b0;
        hold  = 1'b0;
        rdy   = 1'b1;
        reset = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_wen   = 1'b0;
        #1 check("rr_credits_back", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b0;
        send(1'b0, 12'h012, 16'h0000);
        wait_idle("rr_idle2");
        check("rr_read_after", 32'(last_rsp), 32'h0001);

        // Randomized traffic against the memory model and scoreboard
        for (int c = 0; c < 400; c++) begin
            bus.mem_freeze = ($urandom % 4) == 0;
            rdy            = ($urandom % 3) != 0;
            lat            = 1 + int'($urandom % 4);
            bus.cmd_valid  = 1'($urandom % 2);
            bus.cmd_wen    = 1'($urandom % 2);
            bus.cmd_addr   = 12'(12'h300 + ($urandom % 16));
            bus.cmd_wdata  = 16'($urandom);
            @(negedge clk);
            check("rand_out_cnt", 32'(out_cnt), 32'(m_outst));
        end
        bus.cmd_valid  = 1'b0;
        bus.mem_freeze = 1'b0;
        rdy = 1'b1;
        wait_idle("rand_idle");
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
